// File: rtl/fp_wb_arbiter.sv
// FP write-back arbiter: merges the no-stall FPU pipe with the divider stream.
// Ports: CLK/RST, freeze, pipe_* in, div_* handshake, FP__RD_Write_* out,
// wb_stall_req out; FP_WB_FWD_EN adds RS1/2/3_addr, fwd_hit, FP__RSn_Fwd_Data.
module fp_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FP__MEM_WB_Freeze,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  input  logic        pipe_dp,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [4:0]  div_rd,
  input  logic [63:0] div_data,
  input  logic        div_dp,
  output logic [4:0]  FP__RD_Write_Addr,
  output logic [63:0] FP__RD_Write_Data,
  output logic        FP__Reg_Write_En__EX_MEM,
  output logic        FP__SP_DP__EX_MEM,
`ifdef FP_WB_FWD_EN
  input  logic [4:0]  RS1_addr,
  input  logic [4:0]  RS2_addr,
  input  logic [4:0]  RS3_addr,
  output logic [2:0]  fwd_hit,
  output logic [63:0] FP__RS1_Fwd_Data,
  output logic [63:0] FP__RS2_Fwd_Data,
  output logic [63:0] FP__RS3_Fwd_Data,
`endif
  output logic        wb_stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        dp;
  } wb_ent_t;

  wb_ent_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  stv_q, stv_d;
  logic           en_q, en_d;
  logic [4:0]     addr_q, addr_d;
  logic [63:0]    data_q, data_d;
  logic           dp_q, dp_d;
  logic           stall_q, stall_d;
  logic           push, pop, empty;
  wb_ent_t        head;

  assign div_ready = ~RST & (cnt_q < CW'(DEPTH));
  assign push      = div_valid & div_ready;
  assign empty     = (cnt_q == '0);
  assign head      = mem_q[rd_q];

  always_comb begin
    en_d    = en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dp_d    = dp_q;
    stall_d = 1'b0;
    stv_d   = stv_q;
    pop     = 1'b0;
    if (!FP__MEM_WB_Freeze) begin
      if (pipe_valid) begin
        en_d   = 1'b1;
        addr_d = pipe_rd;
        data_d = pipe_data;
        dp_d   = pipe_dp;
        if (!empty) begin
          // pipe beat a waiting divider result
          if (stv_q == SW'(STARVE_LIMIT - 1)) begin
            stall_d = 1'b1;
            stv_d   = '0;
          end else begin
            stv_d = stv_q + 1'b1;
          end
        end
      end else if (!empty) begin
        en_d   = 1'b1;
        addr_d = head.rd;
        data_d = head.data;
        dp_d   = head.dp;
        pop    = 1'b1;
      end else begin
        en_d = 1'b0;
      end
    end
    if (empty || pop) stv_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dp_q    <= 1'b0;
      stall_q <= 1'b0;
      stv_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      stall_q <= stall_d;
      stv_q   <= stv_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // storage needs no reset; push is already blocked during RST
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= '{rd: div_rd, data: div_data, dp: div_dp};
  end

  assign FP__RD_Write_Addr        = addr_q;
  assign FP__RD_Write_Data        = data_q;
  assign FP__Reg_Write_En__EX_MEM = en_q;
  assign FP__SP_DP__EX_MEM        = dp_q;
  assign wb_stall_req             = stall_q;

`ifdef FP_WB_FWD_EN
  logic [63:0] fwd_img;
  // same NaN-boxed image the register file stores
  assign fwd_img = dp_q ? data_q : {32'hFFFFFFFF, data_q[31:0]};
  assign fwd_hit[0] = en_q & (RS1_addr == addr_q);
  assign fwd_hit[1] = en_q & (RS2_addr == addr_q);
  assign fwd_hit[2] = en_q & (RS3_addr == addr_q);
  assign FP__RS1_Fwd_Data = fwd_img;
  assign FP__RS2_Fwd_Data = fwd_img;
  assign FP__RS3_Fwd_Data = fwd_img;
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: queue-based reference model,
// directed scenarios, then randomized traffic with freeze and reset.
module tb_fp_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] d;
    logic        dp;
  } ent_t;

  logic clk = 1'b0;
  logic rst, frz;
  logic pv, pdp, dv, ddp;
  logic [4:0] prd, drd;
  logic [63:0] pd, dd;
  logic div_ready, en, wdp, wb_stall_req;
  logic [4:0] waddr;
  logic [63:0] wdata;
`ifdef FP_WB_FWD_EN
  logic [4:0] rs1, rs2, rs3;
  logic [2:0] fwd_hit;
  logic [63:0] f1, f2, f3;
`endif

  int total = 0;
  int bad = 0;

  ent_t fq[$];
  ent_t expq[$];
  ent_t me;
  int starve = 0;
  logic m_stall = 1'b0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  fp_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(clk), .RST(rst), .FP__MEM_WB_Freeze(frz),
    .pipe_valid(pv), .pipe_rd(prd), .pipe_data(pd), .pipe_dp(pdp),
    .div_valid(dv), .div_ready(div_ready), .div_rd(drd),
    .div_data(dd), .div_dp(ddp),
    .FP__RD_Write_Addr(waddr), .FP__RD_Write_Data(wdata),
    .FP__Reg_Write_En__EX_MEM(en), .FP__SP_DP__EX_MEM(wdp),
`ifdef FP_WB_FWD_EN
    .RS1_addr(rs1), .RS2_addr(rs2), .RS3_addr(rs3),
    .fwd_hit(fwd_hit), .FP__RS1_Fwd_Data(f1),
    .FP__RS2_Fwd_Data(f2), .FP__RS3_Fwd_Data(f3),
`endif
    .wb_stall_req(wb_stall_req)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // reference: what the edge just taken should have done
  task automatic model_update();
    bit ne, rdy;
    logic ns;
    if (rst) begin
      fq.delete();
      expq.delete();
      starve = 0;
      m_stall = 1'b0;
    end else begin
      ne = (fq.size() != 0);
      rdy = (fq.size() < DEPTH);
      ns = 1'b0;
      if (!frz) begin
        if (pv) begin
          expq.push_back('{rd: prd, d: pd, dp: pdp});
          if (ne) begin
            starve++;
            if (starve == LIMIT) begin
              ns = 1'b1;
              starve = 0;
            end
          end else begin
            starve = 0;
          end
        end else if (ne) begin
          expq.push_back(fq.pop_front());
          starve = 0;
        end else begin
          starve = 0;
        end
      end else if (!ne) begin
        starve = 0;
      end
      if (dv && rdy) fq.push_back('{rd: drd, d: dd, dp: ddp});
      m_stall = ns;
    end
    started = 1'b1;
  endtask

  task automatic step(input logic v, input logic [4:0] r,
                      input logic [63:0] d, input logic p,
                      input logic qv, input logic [4:0] qr,
                      input logic [63:0] qd, input logic qp,
                      input logic f, input logic rs);
    pv = v & ~m_stall;
    prd = r; pd = d; pdp = p;
    dv = qv; drd = qr; dd = qd; ddp = qp;
    frz = f; rst = rs;
    @(posedge clk);
    #2;
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: write happens at next edge when en & ~freeze & ~rst
  always @(negedge clk) begin
    if (started) begin
      chk("div_ready", {63'd0, div_ready},
          {63'd0, (!rst && fq.size() < DEPTH)});
      chk("stall", {63'd0, wb_stall_req}, {63'd0, m_stall});
      chk("en", {63'd0, en}, {63'd0, expq.size() != 0});
      if (expq.size() != 0) begin
        me = expq[0];
        chk("wr_addr", {59'd0, waddr}, {59'd0, me.rd});
        chk("wr_data", wdata, me.d);
        chk("wr_dp", {63'd0, wdp}, {63'd0, me.dp});
        if (!rst && !frz) void'(expq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0)
      assert (!(pv && wb_stall_req))
      else begin
        bad++;
        $error("FAIL protocol: pipe_valid while wb_stall_req");
      end
  end

  initial begin : main
    int sc;
    logic lf, hv, hp;
    logic [4:0] hr;
    logic [63:0] hd;
`ifdef FP_WB_FWD_EN
    rs1 = 5'd1; rs2 = 5'd4; rs3 = 5'd2;
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_en", {63'd0, en}, 64'd0);
    chk("rst_addr", {59'd0, waddr}, 64'd0);
    chk("rst_data", wdata, 64'd0);
    chk("rst_dp", {63'd0, wdp}, 64'd0);
    chk("rst_ready", {63'd0, div_ready}, 64'd0);
    idle(1);

    // pipe only
    step(1, 5, 64'h40FE240000000000, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pipe_en", {63'd0, en}, 64'd1);
    chk("pipe_addr", {59'd0, waddr}, 64'd5);
    chk("pipe_data", wdata, 64'h40FE240000000000);
    idle(1);
    #1;
    chk("pipe_en_off", {63'd0, en}, 64'd0);

    // collision
    step(1, 3, 64'h33, 0, 1, 7, 64'h77, 1, 0, 0);
    #1;
    chk("col_first", {59'd0, waddr}, 64'd3);
    chk("col_ready", {63'd0, div_ready}, 64'd1);
    idle(1);
    #1;
    chk("col_second", {59'd0, waddr}, 64'd7);
    idle(2);

    // fill FIFO while pipe keeps winning
    for (int i = 0; i < 4; i++)
      step(1, 5'(i), 64'(i), 1, 1, 5'(20 + i), 64'(100 + i), 0, 0, 0);
    #1;
    chk("fill_ready", {63'd0, div_ready}, 64'd0);
    sc = 0;
    while (!wb_stall_req && sc < 30) begin
      step(1, 5'(sc), 64'(200 + sc), 1, 0, 0, 0, 0, 0, 0);
      sc++;
    end
    chk("fill_stall_seen", {63'd0, wb_stall_req}, 64'd1);
    step(1, 1, 64'd1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fill_head", {59'd0, waddr}, 64'd20);
    chk("fill_ready_back", {63'd0, div_ready}, 64'd1);
    idle(6);

    // freeze holds outputs
    step(1, 9, 64'h99, 1, 0, 0, 0, 0, 0, 0);
    step(1, 10, 64'hA0, 0, 1, 11, 64'hB0, 1, 1, 0);
    step(1, 10, 64'hA0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 10, 64'hA0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("frz_hold", {59'd0, waddr}, 64'd9);
    step(1, 10, 64'hA0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("frz_release", {59'd0, waddr}, 64'd10);
    idle(1);
    #1;
    chk("frz_queued", {59'd0, waddr}, 64'd11);
    idle(2);

    // reset with queued entries
    for (int i = 0; i < 3; i++)
      step(1, 5'(i), 64'(i), 0, 1, 5'(12 + i), 64'(300 + i), 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("mrst_en", {63'd0, en}, 64'd0);
    chk("mrst_ready_low", {63'd0, div_ready}, 64'd0);
    idle(1);
    #1;
    chk("mrst_ready", {63'd0, div_ready}, 64'd1);
    idle(4);

`ifdef FP_WB_FWD_EN
    step(1, 4, 64'h0000000012345678, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fwd_hit", {61'd0, fwd_hit}, 64'd2);
    chk("fwd_data", f2, 64'hFFFFFFFF12345678);
    idle(1);
`endif

    // random traffic
    lf = 1'b0; hv = 1'b0; hp = 1'b0; hr = '0; hd = '0;
    for (int n = 0; n < 600; n++) begin
      logic f;
      if (!lf) begin
        hv = ($urandom % 4) != 0;
        hr = 5'($urandom);
        hd = {$urandom, $urandom};
        hp = 1'($urandom);
      end
      f = ($urandom % 6) == 0;
      step(hv, hr, hd, hp, 1'($urandom), 5'($urandom),
           {$urandom, $urandom}, 1'($urandom), f,
           ($urandom % 150) == 0);
      lf = f;
    end
    idle(8);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
